// File: rtl/sbase_trigger_debounce.sv
//------------------------------------------------------------------------------
// sbase_trigger_debounce : synchronise, debounce and pulse-encode a raw key line
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sbase_trigger_debounce #(
    parameter int BW          = 20,
    parameter int DB_LEN      = 1000000,
    parameter bit KEY_ACT_LOW = 1'b1
) (
    input  logic CLK,
    input  logic RN,
    input  logic KEY_IN,
    output logic KEY_LEVEL,
    output logic TRG_ONE,
    output logic REL_ONE
);

    localparam logic          c_RELEASED = KEY_ACT_LOW;
    localparam logic [BW-1:0] c_CNT_LAST = BW'(DB_LEN - 1);
    localparam logic [BW-1:0] c_CNT_ONE  = BW'(1);

    localparam logic [1:0] c_S_IDLE_LO = 2'd0;
    localparam logic [1:0] c_S_WAIT_HI = 2'd1;
    localparam logic [1:0] c_S_IDLE_HI = 2'd2;
    localparam logic [1:0] c_S_WAIT_LO = 2'd3;

    logic          r_sync1;
    logic          r_sync2;
    logic [1:0]    r_state;
    logic [BW-1:0] r_cnt;
    logic          r_level;
    logic          r_trg;
    logic          r_rel;

    logic          w_key_s;
    logic [1:0]    w_state_nxt;
    logic [BW-1:0] w_cnt_nxt;
    logic          w_level_nxt;
    logic          w_trg_nxt;
    logic          w_rel_nxt;

    // Internal sense is 1 = pressed regardless of the pin polarity.
    assign w_key_s = r_sync2 ^ KEY_ACT_LOW;

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_sync1 <= c_RELEASED;
            r_sync2 <= c_RELEASED;
            r_state <= c_S_IDLE_LO;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_trg   <= 1'b0;
            r_rel   <= 1'b0;
        end else begin
            r_sync1 <= KEY_IN;
            r_sync2 <= r_sync1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_trg   <= w_trg_nxt;
            r_rel   <= w_rel_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        case (r_state)
            c_S_IDLE_LO: begin
                if (w_key_s) w_state_nxt = c_S_WAIT_HI;
            end
            c_S_WAIT_HI: begin
                if (!w_key_s)                 w_state_nxt = c_S_IDLE_LO;
                else if (r_cnt == c_CNT_LAST) w_state_nxt = c_S_IDLE_HI;
                else                          w_cnt_nxt   = r_cnt + c_CNT_ONE;
            end
            c_S_IDLE_HI: begin
                if (!w_key_s) w_state_nxt = c_S_WAIT_LO;
            end
            c_S_WAIT_LO: begin
                if (w_key_s)                  w_state_nxt = c_S_IDLE_HI;
                else if (r_cnt == c_CNT_LAST) w_state_nxt = c_S_IDLE_LO;
                else                          w_cnt_nxt   = r_cnt + c_CNT_ONE;
            end
            default: begin
                w_state_nxt = c_S_IDLE_LO;
            end
        endcase
    end

    // Pulses default low; only the accepting transition raises one.
    always_comb begin
        w_level_nxt = r_level;
        w_trg_nxt   = 1'b0;
        w_rel_nxt   = 1'b0;
        case (r_state)
            c_S_WAIT_HI: begin
                if (w_key_s && (r_cnt == c_CNT_LAST)) begin
                    w_level_nxt = 1'b1;
                    w_trg_nxt   = 1'b1;
                end
            end
            c_S_WAIT_LO: begin
                if (!w_key_s && (r_cnt == c_CNT_LAST)) begin
                    w_level_nxt = 1'b0;
                    w_rel_nxt   = 1'b1;
                end
            end
            default: begin
                w_level_nxt = r_level;
            end
        endcase
    end

    assign KEY_LEVEL = r_level;
    assign TRG_ONE   = r_trg;
    assign REL_ONE   = r_rel;

endmodule

`default_nettype wire
